// File: rtl/tile_pkg.sv
// rtl/tile_pkg.sv - shared constants, palette and swap state encoding for the tile renderer
package tile_pkg;

  localparam int COLOR_W = 3;

  localparam int GRID_W_DEF     = 10;
  localparam int GRID_H_DEF     = 20;
  localparam int CELL_SHIFT_DEF = 4;
  localparam int ORIGIN_X_DEF   = 240;
  localparam int ORIGIN_Y_DEF   = 80;

  localparam logic [23:0] BORDER_RGB = 24'h404040;

  localparam logic [23:0] PALETTE [8] = '{
    24'h000000, 24'h00FFFF, 24'hFFFF00, 24'hFF00FF,
    24'h00FF00, 24'hFF0000, 24'h0000FF, 24'hFF8000
  };

  typedef enum logic [0:0] {
    SWAP_IDLE    = 1'b0,
    SWAP_PENDING = 1'b1
  } swap_state_e;

endpackage

// File: rtl/tile_ram.sv
// rtl/tile_ram.sv - simple dual-port cell storage, one write port and one registered read port
module tile_ram
  import tile_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = COLOR_W
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // Left unreset so the array maps onto block RAM; contents survive rst_n.
  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/tile_renderer.sv
// rtl/tile_renderer.sv - double-buffered tile playfield pixel source with frame-aligned bank swap
module tile_renderer
  import tile_pkg::*;
#(
  parameter int GRID_W     = GRID_W_DEF,
  parameter int GRID_H     = GRID_H_DEF,
  parameter int CELL_SHIFT = CELL_SHIFT_DEF,
  parameter int ORIGIN_X   = ORIGIN_X_DEF,
  parameter int ORIGIN_Y   = ORIGIN_Y_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic       pix_de,
  input  logic       frame_start,
  input  logic       wr_en,
  input  logic [3:0] wr_x,
  input  logic [4:0] wr_y,
  input  logic [2:0] wr_color,
  input  logic       swap_req,
  output logic       swap_pending,
  output logic       swap_done,
  output logic [7:0] rgb_r,
  output logic [7:0] rgb_g,
  output logic [7:0] rgb_b,
  output logic       rgb_de
);

  localparam logic [0:0] ST_IDLE    = SWAP_IDLE;
  localparam logic [0:0] ST_PENDING = SWAP_PENDING;

  localparam logic [9:0] X_LO = 10'(ORIGIN_X);
  localparam logic [9:0] Y_LO = 10'(ORIGIN_Y);
  localparam logic [9:0] X_HI = 10'(ORIGIN_X + (GRID_W << CELL_SHIFT));
  localparam logic [9:0] Y_HI = 10'(ORIGIN_Y + (GRID_H << CELL_SHIFT));

  logic       front;
  logic [0:0] state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      front     <= 1'b0;
      swap_done <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A request never completes in its own cycle, even alongside frame_start.
          if (swap_req) begin
            state <= ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (frame_start) begin
            front     <= ~front;
            swap_done <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign swap_pending = (state == ST_PENDING);

  logic       wr_ok;
  logic [7:0] wr_cell;
  logic [8:0] wr_addr;

  assign wr_ok   = wr_en && (32'(wr_x) < GRID_W) && (32'(wr_y) < GRID_H);
  assign wr_cell = 8'(32'(wr_y) * GRID_W + 32'(wr_x));
  assign wr_addr = {~front, wr_cell};

  logic       in_x, in_y, in_rect;
  logic [9:0] off_x, off_y;
  logic [9:0] cell_x, cell_y;
  logic [7:0] rd_cell;
  logic [8:0] rd_addr;
  logic       border;

  assign in_x    = (pix_x >= X_LO) && (pix_x < X_HI);
  assign in_y    = (pix_y >= Y_LO) && (pix_y < Y_HI);
  assign in_rect = in_x && in_y;
  assign off_x   = pix_x - X_LO;
  assign off_y   = pix_y - Y_LO;
  assign cell_x  = off_x >> CELL_SHIFT;
  assign cell_y  = off_y >> CELL_SHIFT;
  assign border  = (off_x[CELL_SHIFT-1:0] == '0) || (off_y[CELL_SHIFT-1:0] == '0);
  assign rd_cell = in_rect ? 8'(32'(cell_y) * GRID_W + 32'(cell_x)) : 8'd0;
  assign rd_addr = {front, rd_cell};

  logic [COLOR_W-1:0] rd_color;

  tile_ram #(
    .ADDR_W(9),
    .DATA_W(COLOR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_ok),
    .wr_addr(wr_addr),
    .wr_data(wr_color),
    .rd_addr(rd_addr),
    .rd_data(rd_color)
  );

  logic s1_de, s1_in, s1_border;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_de     <= 1'b0;
      s1_in     <= 1'b0;
      s1_border <= 1'b0;
    end else begin
      s1_de     <= pix_de;
      s1_in     <= in_rect;
      s1_border <= border;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_de <= 1'b0;
      {rgb_r, rgb_g, rgb_b} <= 24'h000000;
    end else begin
      rgb_de <= s1_de;
      if (!s1_de || !s1_in) begin
        {rgb_r, rgb_g, rgb_b} <= 24'h000000;
      end else if (s1_border) begin
        {rgb_r, rgb_g, rgb_b} <= BORDER_RGB;
      end else begin
        {rgb_r, rgb_g, rgb_b} <= PALETTE[rd_color];
      end
    end
  end

endmodule

// File: tb/tb_tile_renderer.sv
// tb/tb_tile_renderer.sv - directed self-checking bench for tile_renderer
module tb_tile_renderer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] pix_x = '0;
  logic [9:0] pix_y = '0;
  logic       pix_de = 1'b0;
  logic       frame_start = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] wr_x = '0;
  logic [4:0] wr_y = '0;
  logic [2:0] wr_color = '0;
  logic       swap_req = 1'b0;
  logic       swap_pending, swap_done, rgb_de;
  logic [7:0] rgb_r, rgb_g, rgb_b;

  int passed = 0;
  int total  = 0;

  always #20 clk = ~clk;

  tile_renderer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_x       (pix_x),
    .pix_y       (pix_y),
    .pix_de      (pix_de),
    .frame_start (frame_start),
    .wr_en       (wr_en),
    .wr_x        (wr_x),
    .wr_y        (wr_y),
    .wr_color    (wr_color),
    .swap_req    (swap_req),
    .swap_pending(swap_pending),
    .swap_done   (swap_done),
    .rgb_r       (rgb_r),
    .rgb_g       (rgb_g),
    .rgb_b       (rgb_b),
    .rgb_de      (rgb_de)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr(input int x, input int y, input int c);
    wr_en = 1'b1;
    wr_x = 4'(x);
    wr_y = 5'(y);
    wr_color = 3'(c);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic de,
                     input logic [23:0] exp_rgb);
    pix_x = 10'(x);
    pix_y = 10'(y);
    pix_de = de;
    tick();
    tick();
    chk(tag, {rgb_r, rgb_g, rgb_b}, exp_rgb);
    chk({tag, "_de"}, 24'(rgb_de), 24'(de));
    pix_de = 1'b0;
  endtask

  task automatic clear_back();
    for (int y = 0; y < 20; y++)
      for (int x = 0; x < 10; x++)
        wr(x, y, 0);
  endtask

  initial begin
    // reset
    tick();
    tick();
    chk("rst_rgb", {rgb_r, rgb_g, rgb_b}, 24'h0);
    chk("rst_de", 24'(rgb_de), 24'h0);
    chk("rst_pending", 24'(swap_pending), 24'h0);
    chk("rst_done", 24'(swap_done), 24'h0);
    rst_n = 1'b1;
    pix_x = 10'd300;
    pix_y = 10'd200;
    pix_de = 1'b1;
    chk("post_rst_out0", {rgb_r, rgb_g, rgb_b, 1'b0} >> 1 | 24'(rgb_de), 24'h0);
    tick();
    chk("post_rst_out1_rgb", {rgb_r, rgb_g, rgb_b}, 24'h0);
    chk("post_rst_out1_de", 24'(rgb_de), 24'h0);
    tick();
    chk("post_rst_out2_de", 24'(rgb_de), 24'h1);
    pix_de = 1'b0;

    // fill bank 1 and present it
    clear_back();
    wr(0, 0, 5);
    wr(9, 19, 3);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("pend_after_req", 24'(swap_pending), 24'h1);
    repeat (9) tick();
    chk("pend_waiting", 24'(swap_pending), 24'h1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("swap_done_pulse", 24'(swap_done), 24'h1);
    chk("pend_cleared", 24'(swap_pending), 24'h0);
    tick();
    chk("swap_done_one_cycle", 24'(swap_done), 24'h0);

    pix("cell00", 241, 81, 1'b1, 24'hFF0000);
    pix("border_left", 240, 81, 1'b1, 24'h404040);
    pix("border_inner", 256, 100, 1'b1, 24'h404040);
    pix("outside", 100, 100, 1'b1, 24'h000000);
    pix("de_low", 241, 81, 1'b0, 24'h000000);
    pix("corner_cell", 399, 399, 1'b1, 24'hFF00FF);
    pix("past_right", 400, 200, 1'b1, 24'h000000);

    // same-cycle request and frame_start must not swap
    swap_req = 1'b1;
    frame_start = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_start = 1'b0;
    chk("same_cycle_no_done", 24'(swap_done), 24'h0);
    chk("same_cycle_pending", 24'(swap_pending), 24'h1);

    clear_back();
    wr(0, 0, 4);
    wr(0, 4, 1);
    wr(1, 4, 7);
    wr(0, 3, 6);
    wr(10, 3, 2);
    pix("back_invisible", 241, 81, 1'b1, 24'hFF0000);
    chk("still_pending", 24'(swap_pending), 24'h1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("swap2_done", 24'(swap_done), 24'h1);
    pix("bank0_cell00", 241, 81, 1'b1, 24'h00FF00);
    pix("dropped_cell04", 241, 145, 1'b1, 24'h00FFFF);
    pix("dropped_cell14", 257, 145, 1'b1, 24'hFF8000);
    pix("dropped_cell03", 241, 129, 1'b1, 24'h0000FF);

    // back to bank 1, then reset during a pending swap
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    pix("bank1_again", 241, 81, 1'b1, 24'hFF0000);
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    chk("pend_before_rst", 24'(swap_pending), 24'h1);
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_mid_pending", 24'(swap_pending), 24'h0);
    chk("rst_mid_rgb", {rgb_r, rgb_g, rgb_b}, 24'h0);
    rst_n = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("rst_discarded_swap", 24'(swap_done), 24'h0);
    pix("rst_front0_cell00", 241, 81, 1'b1, 24'h00FF00);
    pix("rst_front0_cell04", 241, 145, 1'b1, 24'h00FFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/tile_renderer.md
# tile_renderer

Pixel source for the VGA output stage in the 25 MHz pixel domain. Takes per-pixel coordinates and data-enable from the VGA timing logic and returns 8-bit RGB two cycles later. The game logic writes a double-buffered cell grid that is drawn as a bordered playfield at a fixed screen origin. Buffer swaps take effect only at frame boundaries, so a frame is never drawn half-updated.

## Interface
- GRID_W, 10, playfield width in cells
- GRID_H, 20, playfield height in cells
- CELL_SHIFT, 4, log2 of cell size in pixels (16 px cells)
- ORIGIN_X, 240, screen x of the playfield's left edge
- ORIGIN_Y, 80, screen y of the playfield's top edge
- clk  in  1  pixel clock (25 MHz domain)
- rst_n  in  1  reset; one clock, synchronous, active-low
- pix_x  in  10  current pixel column
- pix_y  in  10  current pixel row
- pix_de  in  1  visible-region enable for pix_x/pix_y
- frame_start  in  1  one-cycle pulse at the first blanking line after the visible region
- wr_en  in  1  cell write strobe
- wr_x  in  4  cell column
- wr_y  in  5  cell row
- wr_color  in  3  palette index
- swap_req  in  1  one-cycle request to present the back bank
- swap_pending  out  1  swap accepted, waiting for frame_start
- swap_done  out  1  one-cycle pulse when the swap has taken effect
- rgb_r, rgb_g, rgb_b  out  8 each  pixel colour
- rgb_de  out  1  pix_de delayed to match the RGB outputs

## Operation
- Storage holds two banks of GRID_W*GRID_H 3-bit entries.
  - Cell address = y*GRID_W + x, 8 bits. Bank bit is the MSB, giving a 9-bit address.
  - RAM is not reset and its contents are undefined at power-up. The game clears the grid itself.
- The register front (reset 0) selects the bank that is rendered.
- Writes always go to bank ~front, using the value of front in the same cycle.
  - Consequence: a write in the cycle front toggles lands in the new front bank.
  - Writes with wr_x >= GRID_W or wr_y >= GRID_H are dropped.
- Swap FSM, states IDLE and PENDING:
  - IDLE + swap_req -> PENDING, even if frame_start is high in the same cycle. No same-cycle swap.
  - PENDING + frame_start -> toggle front, go to IDLE.
  - swap_req while PENDING is ignored.
  - swap_pending = (state == PENDING).
- Render per pixel:
  - Outside the playfield rectangle [ORIGIN, ORIGIN + GRID*16): RGB 000000.
  - Inside, where the local x or y offset within a cell is 0: border colour 404040.
  - Otherwise: palette[cell].
  - pix_de = 0 forces RGB 000000.
  - Range compare uses the full 10-bit width. Cell index = (pix - ORIGIN) >> CELL_SHIFT, computed only inside the range.
- Palette indices 0-7: 000000, 00FFFF, FFFF00, FF00FF, 00FF00, FF0000, 0000FF, FF8000.

## Timing
- Render latency is 2 cycles and fully pipelined, one pixel per cycle.
  - Stage 1: in-range/border flags and address are registered, and the synchronous RAM read is issued.
  - Stage 2: palette lookup into the output registers.
  - rgb_de(t+2) = pix_de(t).
- Swap sequence:
  - frame_start is sampled in PENDING at cycle t.
  - front toggles at the t+1 edge, and swap_pending falls in that same cycle.
  - swap_done is high for exactly cycle t+1.
  - Pixels sampled from cycle t+1 onward read the new front bank.
- Writes are visible to the render read one cycle after the wr_en cycle. They only reach the screen after a swap.
- Reset values:
  - rgb_r/g/b = 0, rgb_de = 0, pipeline flags = 0.
  - front = 0, state = IDLE, swap_pending = 0, swap_done = 0.
- Reset mid-operation:
  - A pending swap is discarded and front keeps its reset value of 0.
  - RAM contents are retained.
  - Pipeline contents are flushed, so the first two post-reset outputs are 0.

## Structure
- Package tile_pkg holds:
  - COLOR_W = 3, PALETTE[8] of 24-bit constants, BORDER_RGB = 24'h404040.
  - Default grid and origin constants.
  - The swap state enum.
- Sub-module tile_ram: simple dual-port, one write port and one synchronous read port, 512x3, inferring block RAM.
- tile_renderer contains the swap FSM, the address and range logic, and the two pipeline stages.

## Test plan
- Reset: hold rst_n low for 2 cycles -> rgb = 0, rgb_de = 0, swap_pending = 0, swap_done = 0. Drive pix_de = 1 at (300,200) right after release -> first two outputs are 0.
- Write (0,0) = 5, pulse swap_req, then frame_start 10 cycles later -> swap_done pulses one cycle after frame_start. Then pix (241,81) with de = 1 -> 2 cycles later RGB FF0000, rgb_de = 1.
- Geometry, after the previous step:
  - (240,81) -> 404040.
  - (256,100) -> 404040.
  - (100,100) -> 000000.
  - (241,81) with pix_de = 0 -> 000000, rgb_de = 0.
  - (399,399) -> palette of cell (9,19).
- swap_req and frame_start in the same cycle -> no swap, swap_pending = 1. Swap completes only at the next frame_start. Back-bank writes made before it stay invisible until then.
- Write wr_x = 10, wr_y = 3, colour 2 -> dropped. After a swap, cell (0,4) and its neighbours are unchanged.
- rst_n low while PENDING -> swap_pending = 0 and front = 0. Previously written front-bank cells still render correctly after release.
